sad_min_tracker: RTL and testbench
==================================

// Module: sad_min_tracker
// PURPOSE
//  Downstream of the PE row stage in motion estimation. Accumulates ROWS registered row SADs per candidate into a block SAD.
//  Keeps the running minimum over a full +/-SR search window and reports the best SAD and motion vector.
//  Pulses done once per block search.
// PARAMETERS
//  ROW_W  11  width of incoming row SAD (8 x 8-bit abs diffs)
//  ROWS   8   rows per candidate block
//  SAD_W  14  block SAD width; exact, ROWS*(2^ROW_W-1) < 2^SAD_W, no saturation needed
//  SR     16  search range; candidates per axis = 2*SR, offsets -SR..SR-1
//  MV_W   5   signed two's-complement MV component width, clog2(2*SR)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous active-low reset
//  start      in   1      pulse: begin new block search (accepted in any state)
//  pause      in   1      1 = freeze all state; row_valid ignored
//  row_valid  in   1      qualifies row_sad this cycle
//  row_sad    in   ROW_W  unsigned row SAD from PE line
//  busy       out  1      search in progress
//  best_sad   out  SAD_W  running/final minimum block SAD
//  best_mv_x  out  MV_W   signed x offset of best_sad
//  best_mv_y  out  MV_W   signed y offset of best_sad
//  done       out  1      search complete; outputs final
// BEHAVIOUR
//  Reset (rst=0 at clk edge): FSM=IDLE, busy=0, done=0, best_sad=all ones, best_mv_x/y=0, row/cand counters=0, acc=0.
//  FSM states:
//   IDLE->ACCUM on start.
//   ACCUM->DONE on the accepted last row of the last candidate.
//   DONE->IDLE after one unpaused cycle.
//  start (any state, pause=0): best_sad<=all ones; mv<=0; acc, counters<=0; busy<=1; done<=0.
//   An in-flight search is discarded. start with pause=1 is ignored.
//  Row accept = ACCUM & row_valid & !pause & !start. row_valid in IDLE/DONE is ignored.
//  Non-final rows (row_cnt<ROWS-1): acc<=acc+row_sad; row_cnt++.
//  Final row: blk = acc+row_sad (SAD_W, zero-extended). acc<=0; row_cnt<=0.
//   If blk < best_sad (strict), best_sad/mv update at the same edge; ties keep the earlier candidate.
//  Candidate order is raster: x inner, y outer, both -SR..SR-1. cand_x/cand_y are the offsets of the candidate being accumulated.
//   x wraps SR-1 -> -SR and increments y.
//   Last candidate = (SR-1, SR-1), i.e. 4*SR^2 candidates total.
//  Latency: best_* reflect a candidate 1 clk after its final row edge.
//   done=1 and busy=0 in DONE, the cycle after the final row accept.
//  done held while paused in DONE; deasserts on the first unpaused cycle. Outputs hold in IDLE until the next start.
//  pause=1: no register changes at all (FSM, counters, acc, outputs).
// STRUCTURE
//  Shared package me_pkg: ROW_W, ROWS, SAD_W, SR, MV_W constants; state enum {IDLE, ACCUM, DONE}.
//  Sub-module sad_row_acc: acc, row counter, blk/last_row outputs. Parent holds the FSM, candidate counters and min compare.
// TESTING
//  1 Reset mid-search (rst=0 one clk while busy) -> busy=0, done=0, best_sad=16383, mv=(0,0) next cycle.
//  2 SR=2, all rows=10 except candidate (x=1,y=-1) rows=3.
//    -> best_sad=24, mv=(1,-1); done 1 clk after 128th row.
//  3 Tie: candidates (-2,-2) and (0,1) both block SAD 40, all others 80 -> mv=(-2,-2).
//  4 Max value: every row_sad=2047 -> best_sad=16376, mv=(-SR,-SR), no overflow.
//  5 pause asserted 5 clks mid-block while row_valid toggles; start pulsed during pause.
//    -> result identical to an unpaused run; paused start ignored.
//  6 start re-asserted mid-search -> prior partial min discarded.
//    Next done reports only the new search; row_valid gaps (idle cycles) do not shift row counts.

Source files
------------

// File: rtl/me_pkg.sv
// Shared constants and state encoding for the motion-estimation SAD datapath.
package me_pkg;

  localparam int ROW_W     = 11;  // row SAD: 8 x 8-bit absolute differences
  localparam int ROWS      = 8;   // rows per candidate block
  localparam int SAD_W     = 14;  // exact block SAD: ROWS*(2^ROW_W-1) < 2^SAD_W
  localparam int SR        = 16;  // search range, offsets -SR..SR-1
  localparam int MV_W      = 5;   // clog2(2*SR), signed MV component
  localparam int ROW_CNT_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sad_row_acc.sv
// Accumulates ROWS row SADs of one candidate into a block SAD and flags the final row.
module sad_row_acc
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             accept_i,
  input  logic [ROW_W-1:0] row_sad_i,
  output logic [SAD_W-1:0] blk_o,
  output logic             last_row_o
);

  logic [SAD_W-1:0]     acc_q, acc_d;
  logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;

  // Block SAD including the row presented this cycle; only meaningful on the final row.
  assign blk_o      = acc_q + SAD_W'(row_sad_i);
  assign last_row_o = (row_cnt_q == ROW_CNT_W'(ROWS - 1));

  // Next-state for accumulator and row counter.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    acc_d     = acc_q;
    row_cnt_d = row_cnt_q;
    if (clr_i) begin
      acc_d     = '0;
      row_cnt_d = '0;
    end else if (accept_i) begin
      if (last_row_o) begin
        acc_d     = '0;
        row_cnt_d = '0;
      end else begin
        acc_d     = blk_o;
        row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only, so it sits inside the edge-triggered branch.
    if (!rst) begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      acc_q     <= '0;
      row_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      row_cnt_q <= row_cnt_d;
    end
  end

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum block SAD over a raster-ordered +/-SR search window and
// reports best SAD plus motion vector, pulsing done once per block search.
module sad_min_tracker #(
  parameter int SR   = me_pkg::SR,
  parameter int MV_W = $clog2(2 * SR)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     row_valid,
  input  logic [me_pkg::ROW_W-1:0] row_sad,
  output logic                     busy,
  output logic [me_pkg::SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]          best_mv_x,
  output logic [MV_W-1:0]          best_mv_y,
  output logic                     done
);

  import me_pkg::*;

  // Candidate counters run 0..2*SR-1; subtracting SR (mod 2^MV_W) yields the signed offset.
  localparam logic [MV_W-1:0] SR_MV    = MV_W'(SR);
  localparam logic [MV_W-1:0] LAST_IDX = MV_W'(2 * SR - 1);
  localparam logic [MV_W-1:0] ONE_MV   = MV_W'(1);

  state_t           state_q;
  logic             busy_q, done_q;
  logic [SAD_W-1:0] best_sad_q;
  logic [MV_W-1:0]  best_mv_x_q, best_mv_y_q;
  logic [MV_W-1:0]  cnt_x_q, cnt_y_q;

  logic             go;
  logic             accept;
  logic [SAD_W-1:0] blk;
  logic             last_row;
  logic             cand_done;
  logic             last_cand;
  logic             better;

  // A paused start is ignored; a row is only taken while accumulating and not restarting.
  assign go        = start & ~pause;
  assign accept    = (state_q == ACCUM) & row_valid & ~pause & ~start;
  assign cand_done = accept & last_row;
  assign last_cand = (cnt_x_q == LAST_IDX) & (cnt_y_q == LAST_IDX);
  // Strict compare: ties keep the earlier candidate.
  assign better    = (blk < best_sad_q);

  sad_row_acc u_row_acc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (go),
    .accept_i   (accept),
    .row_sad_i  (row_sad),
    .blk_o      (blk),
    .last_row_o (last_row)
  );

  // Search FSM, candidate raster counters and running-minimum registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_sad_q  <= '1;
      best_mv_x_q <= '0;
      best_mv_y_q <= '0;
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
    end else if (go) begin
      state_q     <= ACCUM;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      best_sad_q  <= '1;
      best_mv_x_q <= '0;
      best_mv_y_q <= '0;
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
    end else if (!pause) begin
      case (state_q)
        IDLE: ;
        ACCUM: begin
          if (cand_done) begin
            if (better) begin
              best_sad_q  <= blk;
              best_mv_x_q <= cnt_x_q - SR_MV;
              best_mv_y_q <= cnt_y_q - SR_MV;
            end
            cnt_x_q <= (cnt_x_q == LAST_IDX) ? '0 : cnt_x_q + ONE_MV;
            if (cnt_x_q == LAST_IDX) begin
              cnt_y_q <= (cnt_y_q == LAST_IDX) ? '0 : cnt_y_q + ONE_MV;
            end
            if (last_cand) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign best_sad  = best_sad_q;
  assign best_mv_x = best_mv_x_q;
  assign best_mv_y = best_mv_y_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed bench for sad_min_tracker with SR=2 (16 candidates x 8 rows per search).
module tb_sad_min_tracker;

  localparam int NCAND = 16;
  localparam int NROWS = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic        pause;
  logic        row_valid;
  logic [10:0] row_sad;
  logic        busy;
  logic [13:0] best_sad;
  logic [1:0]  best_mv_x;
  logic [1:0]  best_mv_y;
  logic        done;

  int errors = 0;
  int checks = 0;
  int rows [NCAND];

  sad_min_tracker #(.SR(2), .MV_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .row_valid (row_valid),
    .row_sad   (row_sad),
    .busy      (busy),
    .best_sad  (best_sad),
    .best_mv_x (best_mv_x),
    .best_mv_y (best_mv_y),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full search using rows[] (each candidate's 8 rows share one value).
  task automatic run_search(input string name, input int gap, input int pause_cand,
                            input int exp_sad, input int exp_x, input int exp_y);
    bit early_done = 0;
    bit run_bad    = 0;
    int exp_run    = 16383;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, " busy after start"}, busy, 1);
    check({name, " best cleared"}, best_sad, 16383);
    for (int c = 0; c < NCAND; c++) begin
      for (int r = 0; r < NROWS; r++) begin
        if (c == pause_cand && r == 3) begin
          pause = 1'b1;
          for (int i = 0; i < 5; i++) begin
            row_valid = (i % 2 == 0);
            row_sad   = 11'd1;
            start     = (i == 2);
            tick();
          end
          start     = 1'b0;
          row_valid = 1'b0;
          check({name, " busy held in pause"}, busy, 1);
          check({name, " done low in pause"}, done, 0);
          pause = 1'b0;
        end
        row_valid = 1'b1;
        row_sad   = 11'(rows[c]);
        tick();
        row_valid = 1'b0;
        if (r == NROWS - 1) begin
          if (rows[c] * NROWS < exp_run) exp_run = rows[c] * NROWS;
          if (best_sad !== 14'(exp_run)) run_bad = 1;
        end
        if (!(c == NCAND - 1 && r == NROWS - 1)) begin
          if (done !== 1'b0) early_done = 1;
          for (int g = 0; g < gap; g++) tick();
        end
      end
    end
    check({name, " done"}, done, 1);
    check({name, " busy low at done"}, busy, 0);
    check({name, " best_sad"}, best_sad, exp_sad);
    check({name, " mv_x"}, $signed(best_mv_x), exp_x);
    check({name, " mv_y"}, $signed(best_mv_y), exp_y);
    check({name, " no early done"}, early_done, 0);
    check({name, " running min latency"}, run_bad, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0; row_valid = 1'b0; row_sad = '0;
    tick();
    tick();
    rst = 1'b1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset best_sad", best_sad, 16383);
    check("reset mv_x", $signed(best_mv_x), 0);
    check("reset mv_y", $signed(best_mv_y), 0);

    // 1: reset while busy, after one candidate has set a minimum of 8.
    start = 1'b1; tick(); start = 1'b0;
    for (int r = 0; r < NROWS; r++) begin
      row_valid = 1'b1; row_sad = 11'd1; tick();
    end
    row_valid = 1'b0;
    check("t1 best before reset", best_sad, 8);
    rst = 1'b0; tick(); rst = 1'b1;
    check("t1 busy", busy, 0);
    check("t1 done", done, 0);
    check("t1 best_sad", best_sad, 16383);
    check("t1 mv_x", $signed(best_mv_x), 0);
    check("t1 mv_y", $signed(best_mv_y), 0);

    // 2: single low candidate at (1,-1): index (y+2)*4+(x+2) = 7.
    for (int c = 0; c < NCAND; c++) rows[c] = 10;
    rows[7] = 3;
    run_search("t2", 0, -1, 24, 1, -1);
    tick();
    check("t2 done one cycle", done, 0);

    // 3: tie between (-2,-2)=idx0 and (0,1)=idx14, both 40.
    for (int c = 0; c < NCAND; c++) rows[c] = 10;
    rows[0]  = 5;
    rows[14] = 5;
    run_search("t3", 0, -1, 40, -2, -2);

    // 4: all rows maximal; also done held through pause, rows ignored in IDLE.
    for (int c = 0; c < NCAND; c++) rows[c] = 2047;
    run_search("t4", 0, -1, 16376, -2, -2);
    pause = 1'b1; tick(); tick();
    check("t4 done held in pause", done, 1);
    pause = 1'b0; tick();
    check("t4 done cleared", done, 0);
    check("t4 busy idle", busy, 0);
    row_valid = 1'b1; row_sad = 11'd0;
    tick(); tick(); tick();
    row_valid = 1'b0;
    check("t4 idle rows ignored", best_sad, 16376);
    check("t4 idle busy", busy, 0);

    // 5: pause for 5 cycles inside the winning candidate with toggling row_valid and a start.
    for (int c = 0; c < NCAND; c++) rows[c] = 10;
    rows[7] = 3;
    run_search("t5", 0, 7, 24, 1, -1);
    tick();

    // 6: partial search with a low minimum, then restart; restarted run uses idle gaps.
    for (int c = 0; c < NCAND; c++) rows[c] = 1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3 * NROWS + 4; i++) begin
      row_valid = 1'b1; row_sad = 11'd1; tick();
    end
    row_valid = 1'b0;
    check("t6 partial best", best_sad, 8);
    for (int c = 0; c < NCAND; c++) rows[c] = 10;
    rows[0]  = 5;
    rows[14] = 5;
    run_search("t6", 1, -1, 40, -2, -2);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
